// File: rtl/regfile_scan_checker.sv
// Processor self-check engine: counts a bounded run while tracing register writebacks,
// then borrows regfile read port A and compares every register with an expected-value ROM.
module regfile_scan_checker #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int CYCLE_W     = 16,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [CYCLE_W-1:0]                     num_cycles,
    input  logic [REG_ADDR_W-1:0]                  cpu_rs1,
    input  logic                                   rwe,
    input  logic [REG_ADDR_W-1:0]                  rd,
    input  logic [DATA_WIDTH-1:0]                  rData,
    output logic [REG_ADDR_W-1:0]                  rs1_out,
    input  logic [DATA_WIDTH-1:0]                  regA,
    output logic [REG_ADDR_W-1:0]                  exp_addr,
    input  logic [DATA_WIDTH-1:0]                  exp_data,
    output logic                                   test_mode,
    output logic                                   done,
    output logic                                   pass,
    output logic [REG_ADDR_W:0]                    error_count,
    output logic                                   first_fail_valid,
    output logic [REG_ADDR_W-1:0]                  first_fail_reg,
    output logic [CYCLE_W-1:0]                     cycle_count,
    output logic                                   trace_valid,
    input  logic                                   trace_ready,
    output logic [CYCLE_W+REG_ADDR_W+DATA_WIDTH-1:0] trace_data,
    output logic                                   trace_overflow
);

    localparam int PTR_W   = $clog2(TRACE_DEPTH);
    localparam int TRACE_W = CYCLE_W + REG_ADDR_W + DATA_WIDTH;
    localparam int SCAN_W  = REG_ADDR_W + 1;
    localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'(NUM_REGS);
    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    start_ok_s;
    logic                    test_mode_s;
    logic                    done_s;

    logic [CYCLE_W-1:0]      num_cycles_r;
    logic [CYCLE_W-1:0]      cycle_count_r;

    logic [SCAN_W-1:0]       scan_cnt_r;
    logic [DATA_WIDTH-1:0]   cap_r;
    logic [REG_ADDR_W-1:0]   cap_idx_r;
    logic                    cmp_en_s;
    logic [REG_ADDR_W:0]     error_count_r;
    logic                    ff_valid_r;
    logic [REG_ADDR_W-1:0]   ff_reg_r;

    logic [TRACE_W-1:0]      mem_r [TRACE_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W:0]          fifo_cnt_r;
    logic                    overflow_r;
    logic                    empty_s;
    logic                    full_s;
    logic                    push_req_s;
    logic                    pop_s;
    logic                    do_push_s;
    logic                    drop_s;

    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = (num_cycles == {CYCLE_W{1'b0}}) ? ST_SCAN : ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (cycle_count_r == (num_cycles_r - CYCLE_W'(1))) begin
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SCAN: begin
                if (scan_cnt_r == LAST_SCAN) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        test_mode_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_SCAN: test_mode_s = 1'b1;
            ST_DONE: done_s      = 1'b1;
            default: begin
                test_mode_s = 1'b0;
                done_s      = 1'b0;
            end
        endcase
    end

    // Port A and ROM address steering: the scan index owns both while testing
    always_comb begin
        if (test_mode_s) begin
            rs1_out  = scan_cnt_r[REG_ADDR_W-1:0];
            exp_addr = scan_cnt_r[REG_ADDR_W-1:0];
        end else begin
            rs1_out  = cpu_rs1;
            exp_addr = {REG_ADDR_W{1'b0}};
        end
    end

    // Run length sampling and run-cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            num_cycles_r  <= {CYCLE_W{1'b0}};
            cycle_count_r <= {CYCLE_W{1'b0}};
        end else if (start_ok_s) begin
            num_cycles_r  <= num_cycles;
            cycle_count_r <= {CYCLE_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            cycle_count_r <= cycle_count_r + CYCLE_W'(1);
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    // Scan issue stage: walk indices and capture port A for the compare one cycle later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
            cap_r      <= {DATA_WIDTH{1'b0}};
            cap_idx_r  <= {REG_ADDR_W{1'b0}};
        end else if (state_r == ST_SCAN) begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            if (scan_cnt_r != LAST_SCAN) begin
                cap_r     <= regA;
                cap_idx_r <= scan_cnt_r[REG_ADDR_W-1:0];
            end
        end else begin
            scan_cnt_r <= {SCAN_W{1'b0}};
        end
    end

    assign cmp_en_s = (state_r == ST_SCAN) && (scan_cnt_r != {SCAN_W{1'b0}});

    // Compare stage: indices arrive in ascending order, so the first mismatch is the lowest
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_count_r <= {(REG_ADDR_W + 1){1'b0}};
            ff_valid_r    <= 1'b0;
            ff_reg_r      <= {REG_ADDR_W{1'b0}};
        end else if (start_ok_s) begin
            error_count_r <= {(REG_ADDR_W + 1){1'b0}};
            ff_valid_r    <= 1'b0;
            ff_reg_r      <= {REG_ADDR_W{1'b0}};
        end else if (cmp_en_s && (cap_r != exp_data)) begin
            error_count_r <= error_count_r + (REG_ADDR_W + 1)'(1);
            if (!ff_valid_r) begin
                ff_valid_r <= 1'b1;
                ff_reg_r   <= cap_idx_r;
            end
        end else begin
            error_count_r <= error_count_r;
        end
    end

    assign empty_s    = (fifo_cnt_r == {(PTR_W + 1){1'b0}});
    assign full_s     = (fifo_cnt_r == FIFO_FULL);
    assign push_req_s = (state_r == ST_RUN) && rwe && (rd != {REG_ADDR_W{1'b0}});
    assign pop_s      = trace_ready && !empty_s;
    assign do_push_s  = push_req_s && (!full_s || pop_s);
    assign drop_s     = push_req_s && full_s && !pop_s;

    // Trace storage (no reset needed: entries are only visible once pushed)
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= {cycle_count_r, rd, rData};
        end
    end

    // Trace FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {(PTR_W + 1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (PTR_W + 1)'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (start_ok_s) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign test_mode        = test_mode_s;
    assign done             = done_s;
    assign pass             = done_s && (error_count_r == {(REG_ADDR_W + 1){1'b0}});
    assign error_count      = error_count_r;
    assign first_fail_valid = ff_valid_r;
    assign first_fail_reg   = ff_reg_r;
    assign cycle_count      = cycle_count_r;
    assign trace_valid      = !empty_s;
    assign trace_data       = empty_s ? {TRACE_W{1'b0}} : mem_r[rd_ptr_r];
    assign trace_overflow   = overflow_r;

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Randomised bench for regfile_scan_checker: a queue-based trace model and a
// register/ROM comparison model predict every result the checker reports.
module tb_regfile_scan_checker;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int TD = 16;
    localparam int TW = CW + AW + DW;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [CW-1:0]  num_cycles;
    logic [AW-1:0]  cpu_rs1;
    logic           rwe;
    logic [AW-1:0]  rd;
    logic [DW-1:0]  rData;
    logic [AW-1:0]  rs1_out;
    logic [DW-1:0]  regA;
    logic [AW-1:0]  exp_addr;
    logic [DW-1:0]  exp_data;
    logic           test_mode;
    logic           done;
    logic           pass;
    logic [AW:0]    error_count;
    logic           first_fail_valid;
    logic [AW-1:0]  first_fail_reg;
    logic [CW-1:0]  cycle_count;
    logic           trace_valid;
    logic           trace_ready;
    logic [TW-1:0]  trace_data;
    logic           trace_overflow;

    logic [DW-1:0]  regs [NR];
    logic [DW-1:0]  rom  [NR];
    logic [TW-1:0]  exp_q [$];
    bit             exp_ovf;
    int             checks = 0;
    int             errors = 0;

    regfile_scan_checker dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .cpu_rs1(cpu_rs1), .rwe(rwe), .rd(rd), .rData(rData),
        .rs1_out(rs1_out), .regA(regA), .exp_addr(exp_addr), .exp_data(exp_data),
        .test_mode(test_mode), .done(done), .pass(pass), .error_count(error_count),
        .first_fail_valid(first_fail_valid), .first_fail_reg(first_fail_reg),
        .cycle_count(cycle_count), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .trace_overflow(trace_overflow)
    );

    always #5 clock = ~clock;

    // Harness: combinational regfile read and a one-cycle-latency ROM
    assign regA = regs[rs1_out];
    always @(posedge clock) exp_data <= rom[exp_addr];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One start..done session; rd_mode 0 = random rd, 1 = rd 3 / data 7, 2 = rd 0
    task automatic do_run(input int n, input int wr_pct, input int rdy_pct, input int rd_mode,
                          input logic [NR-1:0] err_mask, input bit drain);
        int exp_err = 0;
        int exp_first = -1;
        int lat;
        int guard;
        bit w;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        for (int i = 0; i < NR; i++) begin
            regs[i] = $urandom;
            if (err_mask[i]) begin
                rom[i] = regs[i] ^ ($urandom | 32'd1);
                exp_err++;
                if (exp_first < 0) exp_first = i;
            end else begin
                rom[i] = regs[i];
            end
        end
        start = 1'b1;
        num_cycles = CW'(n);
        exp_ovf = 1'b0;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        for (int i = 0; i < n; i++) begin
            check_val("run_mode", {63'd0, test_mode}, 64'd0);
            check_val("run_count", {48'd0, cycle_count}, 64'(i));
            cpu_rs1 = AW'($urandom);
            #1;
            check_val("run_rs1", {59'd0, rs1_out}, {59'd0, cpu_rs1});
            w = ($urandom_range(99) < wr_pct);
            r = (rd_mode == 1) ? AW'(3) : (rd_mode == 2) ? AW'(0) : AW'($urandom);
            d = (rd_mode == 1) ? DW'(7) : DW'($urandom);
            rwe = w; rd = r; rData = d;
            trace_ready = ($urandom_range(99) < rdy_pct);
            start = ($urandom_range(3) == 0);
            num_cycles = CW'($urandom);
            if (trace_ready) begin
                if (exp_q.size() > 0) begin
                    check_val("run_head", 64'(trace_data), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end else begin
                    check_val("run_empty", {63'd0, trace_valid}, 64'd0);
                end
            end
            if (w && r != AW'(0)) begin
                if (exp_q.size() < TD) exp_q.push_back({CW'(i), r, d});
                else exp_ovf = 1'b1;
            end
            @(negedge clock);
            lat++;
        end
        rwe = 1'b0;
        trace_ready = 1'b0;
        check_val("scan_mode", {63'd0, test_mode}, 64'd1);
        while (!done && lat < n + 200) begin
            start = ($urandom_range(3) == 0);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check_val("done_lat", 64'(lat - 1), 64'(n + 33));
        check_val("done", {63'd0, done}, 64'd1);
        check_val("pass", {63'd0, pass}, (exp_err == 0) ? 64'd1 : 64'd0);
        check_val("err_cnt", {58'd0, error_count}, 64'(exp_err));
        check_val("ff_valid", {63'd0, first_fail_valid}, (exp_first >= 0) ? 64'd1 : 64'd0);
        if (exp_first >= 0) check_val("ff_reg", {59'd0, first_fail_reg}, 64'(exp_first));
        check_val("overflow", {63'd0, trace_overflow}, {63'd0, exp_ovf});
        check_val("cyc_total", {48'd0, cycle_count}, 64'(n));
        check_val("done_mode", {63'd0, test_mode}, 64'd0);
        if (drain) begin
            guard = 0;
            while (exp_q.size() > 0 && guard < 64) begin
                check_val("drain_valid", {63'd0, trace_valid}, 64'd1);
                check_val("drain_data", 64'(trace_data), 64'(exp_q[0]));
                trace_ready = 1'b1;
                @(negedge clock);
                void'(exp_q.pop_front());
                guard++;
            end
            trace_ready = 1'b0;
            check_val("drain_empty", {63'd0, trace_valid}, 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_cycles = '0; cpu_rs1 = '0;
        rwe = 1'b0; rd = '0; rData = '0; trace_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin regs[i] = '0; rom[i] = '0; end
        repeat (2) @(negedge clock);
        cpu_rs1 = AW'(17);
        #1;
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_mode", {63'd0, test_mode}, 64'd0);
        check_val("rst_pass", {63'd0, pass}, 64'd0);
        check_val("rst_err", {58'd0, error_count}, 64'd0);
        check_val("rst_tvalid", {63'd0, trace_valid}, 64'd0);
        check_val("rst_tdata", 64'(trace_data), 64'd0);
        check_val("rst_ovf", {63'd0, trace_overflow}, 64'd0);
        check_val("rst_rs1", {59'd0, rs1_out}, 64'd17);
        @(negedge clock);
        reset = 1'b0;

        do_run(5, 100, 0, 1, '0, 1'b1);
        do_run(7, 50, 30, 0, 32'h0000_0210, 1'b1);
        do_run(20, 100, 0, 1, '0, 1'b0);
        do_run(20, 100, 100, 0, 32'h8000_0001, 1'b0);

        // Abort mid-scan with mismatches already counted and trace entries held
        for (int i = 0; i < NR; i++) begin regs[i] = $urandom; rom[i] = ~regs[i]; end
        start = 1'b1; num_cycles = CW'(3);
        @(negedge clock);
        start = 1'b0;
        repeat (12) @(negedge clock);
        check_val("pre_abort_mode", {63'd0, test_mode}, 64'd1);
        reset = 1'b1;
        #1;
        check_val("abort_mode", {63'd0, test_mode}, 64'd0);
        check_val("abort_done", {63'd0, done}, 64'd0);
        check_val("abort_err", {58'd0, error_count}, 64'd0);
        check_val("abort_tvalid", {63'd0, trace_valid}, 64'd0);
        check_val("abort_cyc", {48'd0, cycle_count}, 64'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        do_run(4, 60, 20, 0, 32'h0010_0000, 1'b1);
        do_run(8, 100, 0, 2, '0, 1'b1);
        do_run(0, 0, 0, 0, 32'h0000_0004, 1'b1);
        for (int k = 0; k < 6; k++) begin
            do_run($urandom_range(25), $urandom_range(100), $urandom_range(100), 0,
                   NR'($urandom & $urandom & $urandom), k[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
